// File: rtl/filter_mac_pipe.sv
// Three-stage pipelined TAPS-window MAC with shift, clamp/abs saturation and a saturation counter.
// A single global stall (advance) freezes every stage whenever the output is held by the consumer.
module filter_mac_pipe #(
  parameter int TAPS   = 9,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 0,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAPS*PIX_W-1:0]    pix_in,
  input  logic [TAPS*COEF_W-1:0]   coef_in,
  input  logic                     mode_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PIX_W-1:0]         out_pixel,
  output logic                     out_sat,
  output logic [CNT_W-1:0]         sat_count,
  input  logic                     sat_clr
);

  localparam int PW = PIX_W + 1 + COEF_W;
  localparam int SW = PIX_W + COEF_W + 1 + $clog2(TAPS);
  localparam int NP = (TAPS + 1) / 2;
  localparam logic signed [SW:0] PMAX = (SW+1)'((1 << PIX_W) - 1);

  logic                  v1_q, v2_q, out_valid_q;
  logic                  mode1_q, mode2_q;
  logic signed [PW-1:0]  prod_q [TAPS];
  logic signed [PW-1:0]  prod_d [TAPS];
  logic signed [SW-1:0]  part_q [NP];
  logic signed [SW-1:0]  part_d [NP];
  logic signed [SW-1:0]  sum_d;
  logic signed [SW-1:0]  shifted_d;
  logic signed [SW:0]    ext_d, abs_d;
  logic [PIX_W-1:0]      out_pixel_q, pix_d;
  logic                  out_sat_q, sat_d;
  logic [CNT_W-1:0]      sat_count_q;
  logic                  advance;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

  // Pixels gain a zero sign bit so the multiply is fully signed.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod_d[k] = PW'($signed({1'b0, pix_in[k*PIX_W +: PIX_W]})) *
                  PW'($signed(coef_in[k*COEF_W +: COEF_W]));
    end
  end

  always_comb begin
    for (int j = 0; j < NP; j++) part_d[j] = '0;
    for (int k = 0; k < TAPS; k++) part_d[k/2] = part_d[k/2] + SW'(prod_q[k]);
  end

  // Final sum is SW wide by construction; abs is taken one bit wider so the most-negative sum cannot wrap.
  always_comb begin
    sum_d = '0;
    for (int j = 0; j < NP; j++) sum_d = sum_d + part_q[j];
    shifted_d = sum_d >>> SHIFT;
    ext_d     = (SW+1)'(shifted_d);
    abs_d     = (ext_d < 0) ? -ext_d : ext_d;
    pix_d     = '0;
    sat_d     = 1'b0;
    if (mode2_q) begin
      if (abs_d > PMAX) begin
        pix_d = '1;
        sat_d = 1'b1;
      end else begin
        pix_d = abs_d[PIX_W-1:0];
      end
    end else begin
      if (ext_d < 0) begin
        sat_d = 1'b1;
      end else if (ext_d > PMAX) begin
        pix_d = '1;
        sat_d = 1'b1;
      end else begin
        pix_d = ext_d[PIX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      mode1_q     <= 1'b0;
      mode2_q     <= 1'b0;
      out_pixel_q <= '0;
      out_sat_q   <= 1'b0;
      for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
      for (int j = 0; j < NP; j++) part_q[j] <= '0;
    end else if (advance) begin
      v1_q        <= in_valid;
      mode1_q     <= mode_in;
      v2_q        <= v1_q;
      mode2_q     <= mode1_q;
      out_valid_q <= v2_q;
      out_pixel_q <= pix_d;
      out_sat_q   <= sat_d;
      for (int k = 0; k < TAPS; k++) prod_q[k] <= prod_d[k];
      for (int j = 0; j < NP; j++) part_q[j] <= part_d[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count_q <= '0;
    end else if (sat_clr) begin
      sat_count_q <= '0;
    end else if (out_valid_q && out_ready && out_sat_q && (sat_count_q != '1)) begin
      sat_count_q <= sat_count_q + 1'b1;
    end
  end

endmodule
